// File: rtl/execute_port1_wb_arbiter.sv
// execute_port1_wb_arbiter: divider-priority writeback arbiter with an in-order ALU result FIFO
// Define MIST1032SA_WB_ARB_STARVE_EN to force the ALU FIFO through after STARVE_MAX divider wins.
module execute_port1_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int DEPTH_N = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFREE_EX,
    input  logic        iALU_VALID,
    input  logic [55:0] iALU_PAYLOAD,
    output logic        oALU_LOCK,
    input  logic        iDIV_VALID,
    input  logic [44:0] iDIV_PAYLOAD,
    output logic        oDIV_BUSY,
    output logic        oWB_VALID,
    output logic [55:0] oWB_PAYLOAD,
    output logic        oOVERFLOW
);
    localparam logic [DEPTH_N:0] FULL_CNT = (DEPTH_N + 1)'(DEPTH);
    localparam logic [DEPTH_N:0] LOCK_CNT = (DEPTH_N + 1)'(DEPTH - 1);

    logic [55:0] fifo_mem [DEPTH];
    logic [DEPTH_N-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_N:0] count, count_next;
    logic [55:0] div_wb, wb_next;
    logic fifo_empty, fifo_full, div_win, pop, bypass, push, push_ok, drop;

    // Divider results always write a register and never touch the flags.
    assign div_wb = {iDIV_PAYLOAD[44:32], 1'b1, iDIV_PAYLOAD[31:0], 5'h0, 1'b0, 4'h0};

    always_comb begin
        fifo_empty = count == '0;
        fifo_full  = count == FULL_CNT;
        div_win    = iDIV_VALID && !oDIV_BUSY;
        pop        = !div_win && !fifo_empty;
        bypass     = !div_win && fifo_empty && iALU_VALID;
        push       = iALU_VALID && !bypass;
        push_ok    = push && (!fifo_full || pop);
        drop       = push && fifo_full && !pop;
        count_next = count + (DEPTH_N + 1)'(push_ok) - (DEPTH_N + 1)'(pop);
        wb_next    = div_win ? div_wb : pop ? fifo_mem[rd_ptr] : iALU_PAYLOAD;
    end

    always_ff @(posedge iCLOCK) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= iALU_PAYLOAD;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            oALU_LOCK   <= 1'b0;
            oWB_VALID   <= 1'b0;
            oWB_PAYLOAD <= '0;
            oOVERFLOW   <= 1'b0;
        end else if (iFREE_EX) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            oALU_LOCK   <= 1'b0;
            oWB_VALID   <= 1'b0;
            oWB_PAYLOAD <= '0;
            oOVERFLOW   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + DEPTH_N'(push_ok);
            rd_ptr    <= rd_ptr + DEPTH_N'(pop);
            count     <= count_next;
            // One spare slot absorbs the input already in flight when the lock rises.
            oALU_LOCK <= count_next >= LOCK_CNT;
            oWB_VALID <= div_win || pop || bypass;
            if (div_win || pop || bypass)
                oWB_PAYLOAD <= wb_next;
            oOVERFLOW <= oOVERFLOW || drop;
        end
    end

`ifdef MIST1032SA_WB_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    assign oDIV_BUSY = starve_cnt == STARVE_LIM;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)
            starve_cnt <= '0;
        else if (iFREE_EX || pop || count_next == '0)
            starve_cnt <= '0;
        else if (div_win && !fifo_empty && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + SW'(1);
    end
`else
    assign oDIV_BUSY = 1'b0;
`endif

endmodule

// File: tb/tb_execute_port1_wb_arbiter.sv
// tb_execute_port1_wb_arbiter: scoreboard bench for the port-1 writeback arbiter
`timescale 1ns/1ps
module tb_execute_port1_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int SM = 2;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iFREE_EX = 1'b0;
    logic        iALU_VALID = 1'b0;
    logic [55:0] iALU_PAYLOAD = '0;
    logic        iDIV_VALID = 1'b0;
    logic [44:0] iDIV_PAYLOAD = '0;
    logic        oALU_LOCK, oDIV_BUSY, oWB_VALID, oOVERFLOW;
    logic [55:0] oWB_PAYLOAD;

    int n_checks = 0;
    int n_fail = 0;
    logic [55:0] sb [$];
    logic [55:0] mq [$];
    logic        m_ovf = 1'b0;
    logic        m_valid = 1'b0;
    logic [55:0] m_hold = '0;
    int          m_starve = 0;

    execute_port1_wb_arbiter #(.DEPTH(DEPTH), .DEPTH_N(2), .STARVE_MAX(SM)) dut (
        .iCLOCK(iCLOCK),
        .inRESET(inRESET),
        .iFREE_EX(iFREE_EX),
        .iALU_VALID(iALU_VALID),
        .iALU_PAYLOAD(iALU_PAYLOAD),
        .oALU_LOCK(oALU_LOCK),
        .iDIV_VALID(iDIV_VALID),
        .iDIV_PAYLOAD(iDIV_PAYLOAD),
        .oDIV_BUSY(oDIV_BUSY),
        .oWB_VALID(oWB_VALID),
        .oWB_PAYLOAD(oWB_PAYLOAD),
        .oOVERFLOW(oOVERFLOW)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] alu_p(input logic [31:0] d);
        return {6'($urandom), 1'($urandom), 6'($urandom), 1'($urandom), d, 5'($urandom), 1'($urandom), 4'($urandom)};
    endfunction

    function automatic logic [55:0] div_expand(input logic [44:0] p);
        return {p[44:39], p[38], p[37:32], 1'b1, p[31:0], 5'h0, 1'b0, 4'h0};
    endfunction

    task automatic step(input logic av, input logic [31:0] ad, input logic dv, input logic [31:0] dd, input logic fl);
        logic [55:0] ap, win;
        logic busy, divw, nonempty, popped, got_win;
        ap = alu_p(ad);
        win = '0;
        iALU_VALID = av;
        iALU_PAYLOAD = ap;
        iDIV_VALID = dv;
        iDIV_PAYLOAD = {13'(dd * 37 + 11), dd};
        iFREE_EX = fl;
        #1;
`ifdef MIST1032SA_WB_ARB_STARVE_EN
        busy = m_starve == SM;
`else
        busy = 1'b0;
`endif
        check("div_busy", oDIV_BUSY, busy);
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_starve = 0;
            m_valid = 1'b0;
            m_hold = '0;
        end else begin
            divw = dv && !busy;
            nonempty = mq.size() > 0;
            popped = 1'b0;
            got_win = 1'b0;
            if (divw) begin
                got_win = 1'b1;
                win = div_expand(iDIV_PAYLOAD);
                if (av) begin
                    if (mq.size() < DEPTH) mq.push_back(ap);
                    else m_ovf = 1'b1;
                end
            end else if (nonempty) begin
                got_win = 1'b1;
                win = mq.pop_front();
                popped = 1'b1;
                if (av) mq.push_back(ap);
            end else if (av) begin
                got_win = 1'b1;
                win = ap;
            end
            if (popped || mq.size() == 0) m_starve = 0;
            else if (divw && nonempty && m_starve < SM) m_starve++;
            m_valid = got_win;
            if (got_win) begin
                m_hold = win;
                sb.push_back(win);
            end
        end
        @(posedge iCLOCK);
        #1;
        check("wb_valid", oWB_VALID, m_valid);
        if (oWB_VALID) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else check("wb_payload", oWB_PAYLOAD, sb.pop_front());
        end else begin
            check("wb_hold", oWB_PAYLOAD, m_hold);
        end
        check("alu_lock", oALU_LOCK, mq.size() >= DEPTH - 1);
        check("overflow", oOVERFLOW, m_ovf);
    endtask

    initial begin
        repeat (2) @(posedge iCLOCK);
        #1;
        check("rst_valid", oWB_VALID, 0);
        check("rst_payload", oWB_PAYLOAD, 0);
        check("rst_lock", oALU_LOCK, 0);
        check("rst_ovf", oOVERFLOW, 0);
        check("rst_busy", oDIV_BUSY, 0);
        inRESET = 1'b1;
        // bypass with empty FIFO
        step(1, 32'h12345678, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // simultaneous divider and ALU: nothing lost
        step(1, 32'hB, 1, 32'hA, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // three queued ALU results raise the lock, then drain in order
        for (int i = 1; i <= 3; i++) step(1, i, 1, 32'h100 + i, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        // ignore the lock: fifth push overflows, flag stays sticky
        for (int i = 0; i < 5; i++) step(1, 32'h200 + i, 1, 32'h300 + i, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        // flush with two entries and a pending divider result
        step(1, 32'h21, 1, 32'h31, 0);
        step(1, 32'h22, 1, 32'h32, 0);
        step(1, 32'h23, 1, 32'h33, 1);
        step(1, 32'h24, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // divider held valid with one FIFO entry
        step(1, 32'h41, 1, 32'h51, 0);
        repeat (5) step(0, 0, 1, 32'h52, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        // random traffic
        repeat (300) step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 31) == 0);
        repeat (8) step(0, 0, 0, 0, 0);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_port1_wb_arbiter.md
Name: execute_port1_wb_arbiter

Overview:
- Writeback arbiter between the two result sources of execute port 1: single-cycle ALU results (logic/shift/adder/mul/sysreg) and multi-cycle divider results.
- Today a divider result steals the writeback slot and the ALU result in that cycle is lost behind a lock. This block removes that loss.
- ALU results are queued in a small FIFO. The divider gets priority, and one registered writeback bundle is presented to scheduler1/scheduler2.
- Drives the upstream ALU lock and the divider output-busy input.

Parameters:
- DEPTH, 4, ALU result FIFO entries; power of two, at least 2.
- DEPTH_N, 2, log2(DEPTH); the count register is DEPTH_N+1 bits.
- STARVE_MAX, 8, consecutive divider wins while the FIFO is non-empty before the ALU is forced through. Used only with the optional feature.

Ports:
- iCLOCK  in  1  clock, rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iFREE_EX  in  1  synchronous pipeline flush.
- iALU_VALID  in  1  ALU result valid.
- iALU_PAYLOAD  in  56  ALU result: {commit_tag[55:50], sysreg[49], regname[48:43], writeback[42], data[41:10], flag[9:5], flags_wb[4], flags_regname[3:0]}.
- oALU_LOCK  out  1  upstream stall request.
- iDIV_VALID  in  1  divider result valid.
- iDIV_PAYLOAD  in  45  divider result: {commit_tag[44:39], sysreg[38], regname[37:32], data[31:0]}.
- oDIV_BUSY  out  1  divider must hold its output this cycle.
- oWB_VALID  out  1  writeback valid, feeds both schedulers.
- oWB_PAYLOAD  out  56  writeback bundle, same layout as iALU_PAYLOAD.
- oOVERFLOW  out  1  sticky error: an ALU result was dropped.

Behaviour:
- One clock domain (iCLOCK). Reset is asynchronous, active-low (inRESET).
- Reset values: all outputs 0; FIFO empty with count 0; read and write pointers 0; starvation counter 0.
- iFREE_EX (has priority over every event except reset): in the next cycle all state and outputs take their reset values. Inputs presented in the flush cycle are discarded. oOVERFLOW is also cleared.
- Divider payload expansion: writeback=1, flag=5'h0, flags_wb=0, flags_regname=4'h0.
- Arbitration, evaluated each cycle; the winner is registered into oWB_* at the next edge, so latency is 1 cycle.
  1. iDIV_VALID && !oDIV_BUSY: divider wins. An ALU input in the same cycle is pushed to the FIFO.
  2. Otherwise, if the FIFO is non-empty: the FIFO head is popped and wins. A simultaneous ALU input is pushed (push and pop in the same cycle, count unchanged).
  3. Otherwise, if iALU_VALID: bypass. The ALU input goes straight to oWB_* and the FIFO is untouched.
  4. Otherwise oWB_VALID=0. oWB_PAYLOAD holds its previous value.
- ALU ordering: ALU results leave in arrival order. The bypass in rule 3 is legal only when the FIFO is empty.
- Push when the FIFO is full and no pop occurs that cycle: the entry is dropped and oOVERFLOW is set (sticky).
- oALU_LOCK is registered: 1 when the post-update count >= DEPTH-1. This leaves one slot for an input already in flight during the upstream's 1-cycle lock reaction.
- Pointers are DEPTH_N bits and wrap modulo DEPTH. count = number of valid entries, 0..DEPTH.
- oDIV_BUSY is 0 when the optional feature is absent. The divider always wins immediately and never stalls.

Optional Feature:
- Macro: MIST1032SA_WB_ARB_STARVE_EN.
- With the macro:
  - The starvation counter increments on each cycle the divider wins while the FIFO is non-empty. It clears when the FIFO is popped or becomes empty, and saturates at STARVE_MAX.
  - When counter == STARVE_MAX, oDIV_BUSY=1 combinationally for that cycle, the FIFO head wins, and the counter clears.
  - A held divider result stays valid and stable and is granted the following cycle.
- Without the macro: the starvation counter is absent and oDIV_BUSY is tied 0.

Test Plan:
- After reset, drive iALU_VALID for one cycle with data=32'h12345678 and the FIFO empty -> next cycle oWB_VALID=1 with that data; count stays 0; oALU_LOCK=0.
- Drive iDIV_VALID and iALU_VALID in the same cycle, div data=32'hA, alu data=32'hB -> cycle+1 outputs the divider result (writeback=1, flag=0); cycle+2 outputs B; no loss.
- Drive iDIV_VALID for 3 cycles while ALU results 1,2,3 arrive -> oALU_LOCK=1 once count reaches 3; after the divider stops, outputs are 1,2,3 in order; oOVERFLOW=0.
- Ignore oALU_LOCK and push 5 ALU results while the divider is continuously valid (DEPTH=4) -> oOVERFLOW=1 and stays 1 until iFREE_EX.
- Assert iFREE_EX with 2 FIFO entries and a divider result pending -> next cycle oWB_VALID=0, oALU_LOCK=0, oOVERFLOW=0, and the FIFO is empty.
- With the macro defined and STARVE_MAX=2, hold the divider continuously valid with 1 FIFO entry -> 2 divider wins, then oDIV_BUSY=1 for one cycle and the FIFO entry is output, then the held divider result is granted next.
